image_write_packer: RTL and testbench

// - Downstream of the frame reader: takes its 3-pixel beats (Hsync-qualified) and writes them as 72-bit words to frame memory.
// - Restores BMP bottom-up row order so memory matches the original file layout.
// - A FIFO decouples the non-stallable pixel stream from a back-pressured memory write port.
// - Reports frame completion and dropped beats.

---
 rtl/image_write_packer_pkg.sv | 23 ++
 rtl/image_write_packer_if.sv | 12 +
 rtl/image_write_packer_pixel_fifo.sv | 38 +++
 rtl/image_write_packer.sv | 104 ++++++++++
 tb/tb_image_write_packer.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/image_write_packer_pkg.sv
// image_write_packer_pkg: beat geometry, byte-lane order and frame sizing helpers.
package image_write_packer_pkg;
    localparam int PIX_W = 8;
    localparam int PIX_PER_BEAT = 3;
    localparam int BEAT_W = 72;
    localparam int LANE_B0 = 0;
    localparam int LANE_G0 = 1;
    localparam int LANE_R0 = 2;
    localparam int LANE_B1 = 3;
    localparam int LANE_G1 = 4;
    localparam int LANE_R1 = 5;
    localparam int LANE_B2 = 6;
    localparam int LANE_G2 = 7;
    localparam int LANE_R2 = 8;

    function automatic int beats_per_row(int im_width);
        return im_width / PIX_PER_BEAT;
    endfunction

    function automatic int total_beats(int im_width, int im_height);
        return im_width * im_height / PIX_PER_BEAT;
    endfunction
endpackage

// File: rtl/image_write_packer_if.sv
// image_write_packer_if: back-pressured frame-memory write port.
interface image_write_packer_if
    import image_write_packer_pkg::*;
#(parameter int ADDR_W = 17);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [BEAT_W-1:0] wr_data;
    logic              wr_ready;

    modport master(output wr_en, wr_addr, wr_data, input wr_ready);
    modport slave(input wr_en, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/image_write_packer_pixel_fifo.sv
// pixel_fifo: synchronous show-ahead FIFO; dout is the head entry whenever !empty.
module pixel_fifo #(
    parameter int W     = 89,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;

    // Extra pointer bit tells full from empty when the indices coincide.
    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout  = mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/image_write_packer.sv
// image_write_packer: packs 3-pixel beats into 72-bit words, restores BMP bottom-up
// row order and buffers them toward a back-pressured frame-memory write port.
module image_write_packer
    import image_write_packer_pkg::*;
#(
    parameter int Im_width   = 768,
    parameter int Im_height  = 512,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 17
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 Vsync,
    input  logic                 Hsync,
    input  logic [PIX_W-1:0]     R0_in,
    input  logic [PIX_W-1:0]     G0_in,
    input  logic [PIX_W-1:0]     B0_in,
    input  logic [PIX_W-1:0]     R1_in,
    input  logic [PIX_W-1:0]     G1_in,
    input  logic [PIX_W-1:0]     B1_in,
    input  logic [PIX_W-1:0]     R2_in,
    input  logic [PIX_W-1:0]     G2_in,
    input  logic [PIX_W-1:0]     B2_in,
    image_write_packer_if.master wr,
    output logic                 frame_done,
    output logic                 overflow
);
    localparam int BPR   = beats_per_row(Im_width);
    localparam int TOTAL = total_beats(Im_width, Im_height);
    localparam int CW    = BPR > 1 ? $clog2(BPR) : 1;
    localparam int RW    = Im_height > 1 ? $clog2(Im_height) : 1;
    localparam int NW    = $clog2(TOTAL + 1);
    localparam int EW    = ADDR_W + BEAT_W;

    logic              vsync_q, vs_rise;
    logic [CW-1:0]     col, col_e;
    logic [RW-1:0]     row, row_e;
    logic [NW-1:0]     beat_cnt, beat_e, wr_cnt;
    logic              frame_full, accept, push, pop, full, empty, col_wrap;
    logic [ADDR_W-1:0] addr;
    logic [BEAT_W-1:0] data;
    logic [EW-1:0]     head;

    // A beat landing on the Vsync edge is the first beat of the new frame.
    assign vs_rise    = Vsync & ~vsync_q;
    assign col_e      = vs_rise ? '0 : col;
    assign row_e      = vs_rise ? '0 : row;
    assign beat_e     = vs_rise ? '0 : beat_cnt;
    assign frame_full = beat_e == NW'(TOTAL);
    assign accept     = Hsync & ~frame_full;
    assign pop        = wr.wr_en & wr.wr_ready;
    assign push       = accept & (~full | pop);
    assign col_wrap   = col_e == CW'(BPR - 1);
    assign addr       = (ADDR_W'(Im_height - 1) - ADDR_W'(row_e)) * ADDR_W'(BPR) + ADDR_W'(col_e);

    always_comb begin
        data = '0;
        data[LANE_B0*PIX_W +: PIX_W] = B0_in;
        data[LANE_G0*PIX_W +: PIX_W] = G0_in;
        data[LANE_R0*PIX_W +: PIX_W] = R0_in;
        data[LANE_B1*PIX_W +: PIX_W] = B1_in;
        data[LANE_G1*PIX_W +: PIX_W] = G1_in;
        data[LANE_R1*PIX_W +: PIX_W] = R1_in;
        data[LANE_B2*PIX_W +: PIX_W] = B2_in;
        data[LANE_G2*PIX_W +: PIX_W] = G2_in;
        data[LANE_R2*PIX_W +: PIX_W] = R2_in;
    end

    pixel_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .Reset (Reset),
        .push  (push),
        .pop   (pop),
        .din   ({addr, data}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // Gate the head so an empty FIFO never exposes stale storage.
    assign wr.wr_en   = ~empty;
    assign wr.wr_addr = empty ? '0 : head[EW-1:BEAT_W];
    assign wr.wr_data = empty ? '0 : head[BEAT_W-1:0];

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            vsync_q    <= 1'b0;
            col        <= '0;
            row        <= '0;
            beat_cnt   <= '0;
            wr_cnt     <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            vsync_q    <= Vsync;
            col        <= accept ? (col_wrap ? '0 : col_e + 1'b1) : col_e;
            row        <= (accept & col_wrap) ? row_e + 1'b1 : row_e;
            beat_cnt   <= accept ? beat_e + 1'b1 : beat_e;
            wr_cnt     <= (vs_rise ? '0 : wr_cnt) + NW'(pop);
            frame_done <= ~vs_rise & (frame_done | (frame_full & empty));
            overflow   <= (~vs_rise & overflow) | (Hsync & frame_full) | (accept & full & ~pop);
        end
    end
endmodule

// File: tb/tb_image_write_packer.sv
// tb_image_write_packer: scoreboard bench on a 6x4 frame (2 beats/row, 8 words) with a 4-deep FIFO.
module tb_image_write_packer;
    import image_write_packer_pkg::*;

    localparam int W = 6, H = 4, D = 4, AW = 5, BPR = 2, TOT = 8;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [71:0]   d;
    } ent_t;

    logic        clk = 0, Reset = 0, Vsync = 0, Hsync = 0;
    logic [71:0] pix = '0;
    logic        frame_done, overflow;

    ent_t q[$];
    int   log_a[$];
    int   n_chk = 0, n_pass = 0;
    int   mcol = 0, mrow = 0, mbeat = 0;
    logic mfd = 0, movf = 0, prev_vs = 0;
    int   exp_full[8] = '{6, 7, 4, 5, 2, 3, 0, 1};
    int   exp_part[4] = '{6, 7, 4, 5};

    always #5 clk = ~clk;

    image_write_packer_if #(.ADDR_W(AW)) wr_if();

    image_write_packer #(.Im_width(W), .Im_height(H), .FIFO_DEPTH(D), .ADDR_W(AW)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .Vsync      (Vsync),
        .Hsync      (Hsync),
        .B0_in      (pix[7:0]),
        .G0_in      (pix[15:8]),
        .R0_in      (pix[23:16]),
        .B1_in      (pix[31:24]),
        .G1_in      (pix[39:32]),
        .R1_in      (pix[47:40]),
        .B2_in      (pix[55:48]),
        .G2_in      (pix[63:56]),
        .R2_in      (pix[71:64]),
        .wr         (wr_if),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    task automatic check(string tag, logic [79:0] got, logic [79:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [71:0] pix_of(int k);
        logic [71:0] p;
        for (int i = 0; i < 9; i++) p[8*i +: 8] = 8'(k * 9 + i + 1);
        return p;
    endfunction

    // One clock: drive, check outputs at negedge against the model, then advance the model.
    task automatic step(logic vs, logic hs, logic [71:0] p, logic rdy);
        bit   popping, vr, full;
        ent_t e;
        Vsync = vs;
        Hsync = hs;
        pix = p;
        wr_if.wr_ready = rdy;
        @(negedge clk);
        check("wr_en", wr_if.wr_en, q.size() != 0);
        check("frame_done", frame_done, mfd);
        check("overflow", overflow, movf);
        if (q.size() != 0) begin
            check("wr_addr", wr_if.wr_addr, q[0].a);
            check("wr_data", wr_if.wr_data, q[0].d);
        end
        popping = q.size() != 0 && rdy;
        vr = vs && !prev_vs;
        prev_vs = vs;
        mfd = !vr && (mfd || (mbeat == TOT && q.size() == 0));
        if (vr) begin
            mcol = 0;
            mrow = 0;
            mbeat = 0;
            movf = 0;
        end
        full = q.size() == D;
        if (popping) begin
            log_a.push_back(int'(q[0].a));
            void'(q.pop_front());
        end
        if (hs) begin
            if (mbeat == TOT) movf = 1;
            else begin
                e.a = AW'((H - 1 - mrow) * BPR + mcol);
                e.d = p;
                if (full && !popping) movf = 1;
                else q.push_back(e);
                mbeat++;
                if (mcol == BPR - 1) begin
                    mcol = 0;
                    mrow++;
                end else mcol++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        mcol = 0;
        mrow = 0;
        mbeat = 0;
        mfd = 0;
        movf = 0;
        prev_vs = 0;
    endtask

    task automatic check_idle_outputs(string tag);
        check({tag, "_en"}, wr_if.wr_en, 0);
        check({tag, "_addr"}, wr_if.wr_addr, 0);
        check({tag, "_data"}, wr_if.wr_data, 0);
        check({tag, "_fd"}, frame_done, 0);
        check({tag, "_ovf"}, overflow, 0);
    endtask

    initial begin
        wr_if.wr_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        Reset = 1;

        // Single beat latency and packing, then the rest of the frame.
        step(1, 0, '0, 1);
        step(0, 0, '0, 1);
        log_a.delete();
        step(0, 1, pix_of(0), 1);
        check("first_en", wr_if.wr_en, 1);
        check("first_addr", wr_if.wr_addr, 6);
        check("first_data", wr_if.wr_data, 72'h090807060504030201);
        for (int k = 1; k < 8; k++) step(0, 1, pix_of(k), 1);
        step(0, 0, '0, 1);
        check("fd_at_last_write", frame_done, 0);
        step(0, 0, '0, 1);
        check("fd_after_last_write", frame_done, 1);
        check("ovf_full_frame", overflow, 0);
        check("order_cnt", log_a.size(), 8);
        for (int i = 0; i < 8; i++) check("order", i < log_a.size() ? log_a[i] : -1, exp_full[i]);

        // Excess beat, then Vsync clears the flags.
        step(0, 1, pix_of(8), 1);
        check("excess_ovf", overflow, 1);
        check("excess_en", wr_if.wr_en, 0);
        step(1, 0, '0, 1);
        check("vs_clr_fd", frame_done, 0);
        check("vs_clr_ovf", overflow, 0);
        step(0, 0, '0, 1);

        // Stalled memory: fifth beat dropped.
        log_a.delete();
        for (int k = 0; k < 5; k++) begin
            step(0, 1, pix_of(k), 0);
            check("stall_ovf", overflow, k == 4);
        end
        repeat (6) step(0, 0, '0, 1);
        check("stall_cnt", log_a.size(), 4);
        for (int i = 0; i < 4; i++) check("stall_order", i < log_a.size() ? log_a[i] : -1, exp_part[i]);
        check("stall_fd", frame_done, 0);

        // Push onto a full FIFO while it pops.
        step(1, 0, '0, 0);
        step(0, 0, '0, 0);
        log_a.delete();
        for (int k = 0; k < 4; k++) step(0, 1, pix_of(k + 20), 0);
        step(0, 1, pix_of(24), 1);
        check("full_pp_ovf", overflow, 0);
        for (int k = 5; k < 8; k++) step(0, 1, pix_of(k + 20), 1);
        repeat (6) step(0, 0, '0, 1);
        check("full_pp_cnt", log_a.size(), 8);
        for (int i = 0; i < 8; i++) check("full_pp_order", i < log_a.size() ? log_a[i] : -1, exp_full[i]);
        check("full_pp_fd", frame_done, 1);
        check("full_pp_ovf_end", overflow, 0);

        // Reset mid-stream, then restart at the first address.
        step(1, 0, '0, 0);
        step(0, 0, '0, 0);
        for (int k = 0; k < 3; k++) step(0, 1, pix_of(k + 40), 0);
        Reset = 0;
        #1;
        check_idle_outputs("midrst");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        Reset = 1;
        step(1, 0, '0, 1);
        step(0, 0, '0, 1);
        step(0, 1, pix_of(50), 1);
        check("restart_addr", wr_if.wr_addr, 6);
        check("restart_data", wr_if.wr_data, pix_of(50));
        repeat (3) step(0, 0, '0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
